// File: rtl/shift_sequencer.sv
// Multi-cycle 32-bit barrel shifter: one stage per clock (16, 8, 4, 2, 1), SLL or SRA.
// Define SHIFT_SEQ_EARLY_EXIT_EN to finish as soon as no remaining shamt bits are set.
module shift_sequencer (
  input  logic        i_clock,
  input  logic        i_reset,
  input  logic        i_start,
  input  logic [31:0] i_data_in,
  input  logic [4:0]  i_shamt,
  input  logic        i_op,
  output logic        o_busy,
  output logic        o_result_valid,
  output logic [31:0] o_result,
  output logic [1:0]  o_dbg_state
);

  // Handshake: i_start is taken on a rising edge only in IDLE or DONE; a result is
  // valid exactly in the cycle o_result_valid is high. i_start during SHIFT is ignored.
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

`ifdef SHIFT_SEQ_EARLY_EXIT_EN
  localparam bit EARLY_EXIT = 1'b1;
`else
  localparam bit EARLY_EXIT = 1'b0;
`endif

  state_t      r_state;
  state_t      w_next_state;
  logic [31:0] r_acc;
  logic [31:0] r_result;
  logic [4:0]  r_shamt;
  logic        r_op;
  logic [2:0]  r_stage;

  logic        w_accept;
  logic        w_accept_done;
  logic        w_stage_en;
  logic        w_rem;
  logic        w_last;
  logic        w_shift_done;
  logic [4:0]  w_dist;
  logic [31:0] w_shifted;
  logic [31:0] w_next_acc;

  assign w_accept = i_start && ((r_state == IDLE) || (r_state == DONE));
  // A zero shift amount has no stage to apply, so early-exit completes on the accepting edge.
  assign w_accept_done = EARLY_EXIT && (i_shamt == 5'd0);

  // Stage k uses shamt bit (4-k); w_rem flags any set bit still to be processed after it.
  always_comb begin
    w_stage_en = 1'b0;
    w_rem      = 1'b0;
    w_last     = 1'b0;
    w_dist     = 5'd1;
    case (r_stage)
      3'd0: begin w_stage_en = r_shamt[4]; w_rem = |r_shamt[3:0]; w_dist = 5'd16; end
      3'd1: begin w_stage_en = r_shamt[3]; w_rem = |r_shamt[2:0]; w_dist = 5'd8;  end
      3'd2: begin w_stage_en = r_shamt[2]; w_rem = |r_shamt[1:0]; w_dist = 5'd4;  end
      3'd3: begin w_stage_en = r_shamt[1]; w_rem = r_shamt[0];    w_dist = 5'd2;  end
      default: begin
        w_stage_en = r_shamt[0];
        w_rem      = 1'b0;
        w_last     = 1'b1;
        w_dist     = 5'd1;
      end
    endcase
  end

  assign w_shifted    = r_op ? $unsigned($signed(r_acc) >>> w_dist) : (r_acc << w_dist);
  assign w_next_acc   = w_stage_en ? w_shifted : r_acc;
  assign w_shift_done = w_last || (EARLY_EXIT && !w_rem);

  always_comb begin
    w_next_state = r_state;
    case (r_state)
      IDLE: begin
        if (i_start) w_next_state = w_accept_done ? DONE : SHIFT;
      end
      SHIFT: begin
        if (w_shift_done) w_next_state = DONE;
      end
      DONE: begin
        if (i_start) w_next_state = w_accept_done ? DONE : SHIFT;
        else         w_next_state = IDLE;
      end
      default: w_next_state = IDLE;
    endcase
  end

  always_ff @(posedge i_clock) begin
    if (i_reset) r_state <= IDLE;
    else         r_state <= w_next_state;
  end

  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      r_acc    <= 32'd0;
      r_shamt  <= 5'd0;
      r_op     <= 1'b0;
      r_stage  <= 3'd0;
      r_result <= 32'd0;
    end else if (w_accept) begin
      r_acc   <= i_data_in;
      r_shamt <= i_shamt;
      r_op    <= i_op;
      r_stage <= 3'd0;
      if (w_accept_done) r_result <= i_data_in;
    end else if (r_state == SHIFT) begin
      r_acc   <= w_next_acc;
      r_stage <= r_stage + 3'd1;
      if (w_shift_done) r_result <= w_next_acc;
    end
  end

  assign o_busy         = (r_state == SHIFT);
  assign o_result_valid = (r_state == DONE);
  assign o_result       = r_result;
  assign o_dbg_state    = r_state;

endmodule
